// File: rtl/par_xfer_pkg.sv
// par_xfer_pkg: state encoding and counter sizing shared by the parallel transfer chain
package par_xfer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/parallel_to_serial_tx_if.sv
// parallel_to_serial_tx_if: word handshake in, serial frame signals out
interface parallel_to_serial_tx_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic sout;
  logic sout_valid;
  logic frame_start;
  logic busy;
  logic done;
  modport master(output din, din_valid, input din_ready, sout, sout_valid, frame_start, busy, done);
  modport slave(input din, din_valid, output din_ready, sout, sout_valid, frame_start, busy, done);
endinterface

// File: rtl/parallel_to_serial_tx.sv
// parallel_to_serial_tx: serialises one word at a time with optional even parity and done pulse
module parallel_to_serial_tx
  import par_xfer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input logic clk,
  input logic rst,
  parallel_to_serial_tx_if.slave s
);
  localparam int N  = WIDTH + PARITY_EN;
  localparam int CW = cnt_w(N);
  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_par;
  logic             w_bit;
  logic [WIDTH-1:0] w_next;
  always_comb begin
    w_bit  = (PARITY_EN != 0 && r_cnt == CW'(WIDTH)) ? r_par
           : (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];
    w_next = (MSB_FIRST != 0) ? r_shreg << 1 : r_shreg >> 1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (s.din_valid) begin
          r_shreg <= s.din;
          r_par   <= ^s.din;
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_shreg <= w_next;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // outputs forced low while reset is asserted, regardless of current state
  assign s.din_ready   = !rst && r_state == IDLE;
  assign s.sout_valid  = !rst && r_state == SHIFT;
  assign s.sout        = !rst && r_state == SHIFT && w_bit;
  assign s.frame_start = !rst && r_state == SHIFT && r_cnt == '0;
  assign s.busy        = !rst && r_state != IDLE;
  assign s.done        = !rst && r_state == DONE;
endmodule
